// File: rtl/ppi_pkg.sv
// ppi_pkg: shared encodings for the strobed parallel port.
// Control-word layout, status bit positions and register selects.
package ppi_pkg;

    typedef enum logic [1:0] {
        MODE_0 = 2'b00,
        MODE_1 = 2'b01
    } mode_e;

    typedef enum logic [1:0] {
        SEL_A   = 2'd0,
        SEL_B   = 2'd1,
        SEL_C   = 2'd2,
        SEL_CTL = 2'd3
    } sel_e;

    localparam logic [7:0] RESET_CW = 8'h9B;

    localparam int CW_FLAG      = 7;
    localparam int CW_MODE_A_HI = 6;
    localparam int CW_MODE_A_LO = 5;
    localparam int CW_DIR_A     = 4;
    localparam int CW_DIR_CU    = 3;
    localparam int CW_MODE_B    = 2;
    localparam int CW_DIR_B     = 1;
    localparam int CW_DIR_CL    = 0;

    localparam int ST_INTR_B = 0;
    localparam int ST_BF_B   = 1;
    localparam int ST_INTE_B = 2;
    localparam int ST_INTR_A = 3;
    localparam int ST_BF_A   = 4;
    localparam int ST_INTE_A = 5;

    localparam int BSR_INTE_A = 4;
    localparam int BSR_INTE_B = 2;

    // Any non-zero port-A mode code behaves as the strobed mode.
    function automatic mode_e mode_a_of(input logic [1:0] f);
        return (f == 2'b00) ? MODE_0 : MODE_1;
    endfunction

endpackage

// File: rtl/ppi_hs_port.sv
// ppi_hs_port: one strobed port with pin synchroniser, input latch,
// buffer-full flag, interrupt request and interrupt enable.
module ppi_hs_port #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode1,
    input  logic              dir_in,
    input  logic              cw_load,
    input  logic              inte_wr,
    input  logic              inte_val,
    input  logic              port_wr,
    input  logic              read_end,
    input  logic              stb_ack_n,
    input  logic [DATA_W-1:0] pin_in,
    output logic [DATA_W-1:0] pin_sync,
    output logic [DATA_W-1:0] latch,
    output logic              bf,
    output logic              intr,
    output logic              inte
);

    logic [DATA_W-1:0]      din_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] hs_q;
    logic                   hs_prev;
    logic                   hs;
    logic                   hs_fall;
    logic [DATA_W-1:0]      latch_n;
    logic                   bf_n;
    logic                   intr_n;
    logic                   inte_n;

    assign pin_sync = din_q[SYNC_STAGES-1];
    assign hs       = hs_q[SYNC_STAGES-1];
    assign hs_fall  = hs_prev & ~hs;

    always_comb begin
        latch_n = latch;
        bf_n    = bf;
        intr_n  = intr;
        inte_n  = inte;
        if (inte_wr) inte_n = inte_val;
        if (!mode1) begin
            bf_n   = 1'b0;
            intr_n = 1'b0;
        end else if (dir_in) begin
            // A strobe on the same edge as a read end keeps the buffer full.
            if (hs_fall) begin
                latch_n = pin_sync;
                bf_n    = 1'b1;
            end else if (read_end) begin
                bf_n = 1'b0;
            end
            intr_n = bf_n & inte_n & hs;
        end else begin
            if (port_wr) begin
                bf_n   = 1'b1;
                intr_n = 1'b0;
            end else begin
                if (hs_fall) bf_n = 1'b0;
                if (!bf && hs && inte) intr_n = 1'b1;
            end
        end
        if (cw_load) begin
            bf_n   = 1'b0;
            intr_n = 1'b0;
            inte_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) din_q[i] <= '0;
            hs_q    <= '0;
            hs_prev <= 1'b0;
            latch   <= '0;
            bf      <= 1'b0;
            intr    <= 1'b0;
            inte    <= 1'b0;
        end else begin
            din_q[0] <= pin_in;
            hs_q[0]  <= stb_ack_n;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                din_q[i] <= din_q[i-1];
                hs_q[i]  <= hs_q[i-1];
            end
            hs_prev <= hs;
            latch   <= latch_n;
            bf      <= bf_n;
            intr    <= intr_n;
            inte    <= inte_n;
        end
    end

endmodule

// File: rtl/ppi_strobed.sv
// ppi_strobed: CPU-facing parallel port with three ports and
// strobed handshakes on ports A and B.
module ppi_strobed
    import ppi_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CS,
    input  logic              RD,
    input  logic              WR,
    input  logic [1:0]        A,
    input  logic [DATA_W-1:0] D_IN,
    output logic [DATA_W-1:0] D_OUT,
    output logic              D_OE,
    input  logic [DATA_W-1:0] PA_IN,
    input  logic [DATA_W-1:0] PB_IN,
    input  logic [DATA_W-1:0] PC_IN,
    output logic [DATA_W-1:0] PA_OUT,
    output logic [DATA_W-1:0] PB_OUT,
    output logic [DATA_W-1:0] PC_OUT,
    output logic              PA_OE,
    output logic              PB_OE,
    output logic [DATA_W-1:0] PC_OE,
    input  logic [1:0]        STB_ACK_N,
    output logic [1:0]        BF,
    output logic [1:0]        INTR
);

    localparam int HALF = DATA_W / 2;

    logic [7:0]        cw;
    logic              wr_q;
    logic              rd_q;
    logic [DATA_W-1:0] pc_q [SYNC_STAGES];
    logic [DATA_W-1:0] pc_sync;
    logic [DATA_W-1:0] c_in;
    logic [DATA_W-1:0] pc_bsr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] pa_sync;
    logic [DATA_W-1:0] pb_sync;
    logic [DATA_W-1:0] pa_latch;
    logic [DATA_W-1:0] pb_latch;
    logic [5:0]        bsr_idx;
    logic              wr_ev;
    logic              cw_wr;
    logic              bsr_wr;
    logic              rd_act;
    logic              rd_end;
    logic              mode_a1;
    logic              mode_b1;
    logic              dir_a;
    logic              dir_b;
    logic              bf_a;
    logic              bf_b;
    logic              intr_a;
    logic              intr_b;
    logic              inte_a;
    logic              inte_b;
    sel_e              sel;

    assign sel     = sel_e'(A);
    assign mode_a1 = (mode_a_of(cw[CW_MODE_A_HI:CW_MODE_A_LO]) == MODE_1);
    assign mode_b1 = cw[CW_MODE_B];
    assign dir_a   = cw[CW_DIR_A];
    assign dir_b   = cw[CW_DIR_B];

    // A write fires once, on the first cycle of the WR strobe.
    assign wr_ev   = ~CS & ~WR & RD & wr_q;
    assign cw_wr   = wr_ev && (sel == SEL_CTL) && D_IN[CW_FLAG];
    assign bsr_wr  = wr_ev && (sel == SEL_CTL) && !D_IN[CW_FLAG];
    assign bsr_idx = 6'(D_IN[6:1] % 6'(DATA_W));
    assign rd_act  = ~CS & ~RD & WR;
    assign rd_end  = ~rd_q & RD & ~CS;

    assign D_OE    = rd_act;
    assign PA_OE   = ~dir_a;
    assign PB_OE   = ~dir_b;
    assign PC_OE   = ~c_in;
    assign pc_sync = pc_q[SYNC_STAGES-1];
    assign BF      = {bf_b, bf_a};
    assign INTR    = {intr_b, intr_a};

    always_comb begin
        c_in   = '0;
        pc_bsr = PC_OUT;
        for (int i = 0; i < DATA_W; i++) begin
            c_in[i] = (i >= HALF) ? cw[CW_DIR_CU] : cw[CW_DIR_CL];
            if (int'(bsr_idx) == i) pc_bsr[i] = D_IN[0];
        end
    end

    always_comb begin
        rd_data = '0;
        unique case (sel)
            SEL_A:   rd_data = dir_a ? (mode_a1 ? pa_latch : pa_sync) : PA_OUT;
            SEL_B:   rd_data = dir_b ? (mode_b1 ? pb_latch : pb_sync) : PB_OUT;
            SEL_C:   rd_data = (pc_sync & c_in) | (PC_OUT & ~c_in);
            SEL_CTL: begin
                rd_data[ST_INTR_B] = intr_b;
                rd_data[ST_BF_B]   = bf_b;
                rd_data[ST_INTE_B] = inte_b;
                rd_data[ST_INTR_A] = intr_a;
                rd_data[ST_BF_A]   = bf_a;
                rd_data[ST_INTE_A] = inte_a;
            end
        endcase
    end

    ppi_hs_port #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) u_port_a (
        .clk      (CLK),
        .reset    (RESET),
        .mode1    (mode_a1),
        .dir_in   (dir_a),
        .cw_load  (cw_wr),
        .inte_wr  (bsr_wr && mode_a1 && (bsr_idx == 6'(BSR_INTE_A))),
        .inte_val (D_IN[0]),
        .port_wr  (wr_ev && (sel == SEL_A)),
        .read_end (rd_end && (sel == SEL_A)),
        .stb_ack_n(STB_ACK_N[0]),
        .pin_in   (PA_IN),
        .pin_sync (pa_sync),
        .latch    (pa_latch),
        .bf       (bf_a),
        .intr     (intr_a),
        .inte     (inte_a)
    );

    ppi_hs_port #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) u_port_b (
        .clk      (CLK),
        .reset    (RESET),
        .mode1    (mode_b1),
        .dir_in   (dir_b),
        .cw_load  (cw_wr),
        .inte_wr  (bsr_wr && mode_b1 && (bsr_idx == 6'(BSR_INTE_B))),
        .inte_val (D_IN[0]),
        .port_wr  (wr_ev && (sel == SEL_B)),
        .read_end (rd_end && (sel == SEL_B)),
        .stb_ack_n(STB_ACK_N[1]),
        .pin_in   (PB_IN),
        .pin_sync (pb_sync),
        .latch    (pb_latch),
        .bf       (bf_b),
        .intr     (intr_b),
        .inte     (inte_b)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cw     <= RESET_CW;
            wr_q   <= 1'b1;
            rd_q   <= 1'b1;
            D_OUT  <= '0;
            PA_OUT <= '0;
            PB_OUT <= '0;
            PC_OUT <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) pc_q[i] <= '0;
        end else begin
            wr_q    <= WR;
            rd_q    <= RD;
            pc_q[0] <= PC_IN;
            for (int i = 1; i < SYNC_STAGES; i++) pc_q[i] <= pc_q[i-1];
            if (rd_act) D_OUT <= rd_data;
            if (cw_wr) begin
                cw     <= D_IN[7:0];
                PA_OUT <= '0;
                PB_OUT <= '0;
                PC_OUT <= '0;
            end else begin
                if (bsr_wr) PC_OUT <= pc_bsr;
                if (wr_ev && (sel == SEL_A)) PA_OUT <= D_IN;
                if (wr_ev && (sel == SEL_B)) PB_OUT <= D_IN;
                if (wr_ev && (sel == SEL_C)) PC_OUT <= D_IN;
            end
        end
    end

endmodule

// File: tb/tb_ppi_strobed.sv
// tb_ppi_strobed: vector table, handshake sequences and randomized
// mode-0 traffic checked against a register-level model.
module tb_ppi_strobed;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs;
    logic       rd;
    logic       wr;
    logic [1:0] a;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic       d_oe;
    logic [7:0] pa_in;
    logic [7:0] pb_in;
    logic [7:0] pc_in;
    logic [7:0] pa_out;
    logic [7:0] pb_out;
    logic [7:0] pc_out;
    logic       pa_oe;
    logic       pb_oe;
    logic [7:0] pc_oe;
    logic [1:0] stb;
    logic [1:0] bf;
    logic [1:0] intr;

    int n_run  = 0;
    int n_fail = 0;

    typedef enum logic [2:0] {OP_WR, OP_RD, OP_PA, OP_PC, OP_OE} op_e;

    typedef struct {
        op_e         op;
        logic [1:0]  addr;
        logic [7:0]  data;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    ppi_strobed #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .CLK      (clk),
        .RESET    (reset),
        .CS       (cs),
        .RD       (rd),
        .WR       (wr),
        .A        (a),
        .D_IN     (d_in),
        .D_OUT    (d_out),
        .D_OE     (d_oe),
        .PA_IN    (pa_in),
        .PB_IN    (pb_in),
        .PC_IN    (pc_in),
        .PA_OUT   (pa_out),
        .PB_OUT   (pb_out),
        .PC_OUT   (pc_out),
        .PA_OE    (pa_oe),
        .PB_OE    (pb_oe),
        .PC_OE    (pc_oe),
        .STB_ACK_N(stb),
        .BF       (bf),
        .INTR     (intr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] got,
                         input logic [15:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cpu_write(input logic [1:0] addr, input logic [7:0] data);
        cs   = 1'b0;
        a    = addr;
        d_in = data;
        rd   = 1'b1;
        wr   = 1'b0;
        tick();
        wr = 1'b1;
        cs = 1'b1;
        tick();
    endtask

    task automatic cpu_read(input logic [1:0] addr, output logic [7:0] data);
        cs = 1'b0;
        a  = addr;
        wr = 1'b1;
        rd = 1'b0;
        tick();
        data = d_out;
        rd   = 1'b1;
        tick();
        cs = 1'b1;
    endtask

    function automatic void add(input op_e op, input logic [1:0] ad,
                                input logic [7:0] dt, input logic [15:0] ex,
                                input string nm);
        vec_t v;
        v.op   = op;
        v.addr = ad;
        v.data = dt;
        v.exp  = ex;
        v.name = nm;
        tbl.push_back(v);
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rdv;
        logic [7:0] cwv;
        logic [7:0] ma;
        logic [7:0] mb;
        logic [7:0] mc;
        logic [7:0] mask;
        logic [7:0] expv;
        logic [7:0] wdat;
        logic [5:0] idx;
        logic [3:0] dirs;
        logic       b;
        int         n;
        int         op;
        int         port;

        reset = 1'b1;
        cs    = 1'b1;
        rd    = 1'b1;
        wr    = 1'b1;
        a     = 2'd0;
        d_in  = 8'h00;
        pa_in = 8'h69;
        pb_in = 8'h4D;
        pc_in = 8'hC6;
        stb   = 2'b11;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        add(OP_RD, 2'd3, 8'h00, 16'h0000, "status_rst");
        add(OP_OE, 2'd0, 8'h00, 16'h0000, "oe_rst");
        add(OP_WR, 2'd3, 8'h80, 16'h0000, "");
        add(OP_WR, 2'd0, 8'hA5, 16'h0000, "");
        add(OP_OE, 2'd0, 8'h00, 16'h03FF, "oe_all_out");
        add(OP_PA, 2'd0, 8'h00, 16'h00A5, "pa_write");
        add(OP_RD, 2'd0, 8'h00, 16'h00A5, "rd_pa_out");
        add(OP_WR, 2'd3, 8'h80, 16'h0000, "");
        add(OP_PA, 2'd0, 8'h00, 16'h0000, "pa_cw_clear");
        add(OP_WR, 2'd2, 8'h33, 16'h0000, "");
        add(OP_WR, 2'd3, 8'h0F, 16'h0000, "");
        add(OP_PC, 2'd0, 8'h00, 16'h00B3, "bsr_set7");
        add(OP_WR, 2'd3, 8'h0E, 16'h0000, "");
        add(OP_PC, 2'd0, 8'h00, 16'h0033, "bsr_clr7");
        add(OP_WR, 2'd3, 8'h12, 16'h0000, "");
        add(OP_PC, 2'd0, 8'h00, 16'h0031, "bsr_idx_mod");
        add(OP_RD, 2'd2, 8'h00, 16'h0031, "rd_pc_out");
        add(OP_WR, 2'd3, 8'h89, 16'h0000, "");
        add(OP_OE, 2'd0, 8'h00, 16'h0300, "oe_mixed");
        add(OP_PC, 2'd0, 8'h00, 16'h0000, "pc_cw_clear");
        add(OP_WR, 2'd1, 8'h5A, 16'h0000, "");
        add(OP_RD, 2'd1, 8'h00, 16'h005A, "rd_pb_out");
        add(OP_RD, 2'd2, 8'h00, 16'h00C6, "rd_pc_pins");
        add(OP_WR, 2'd3, 8'h9B, 16'h0000, "");
        add(OP_RD, 2'd0, 8'h00, 16'h0069, "rd_pa_pins");
        add(OP_RD, 2'd1, 8'h00, 16'h004D, "rd_pb_pins");

        foreach (tbl[i]) begin
            case (tbl[i].op)
                OP_WR: cpu_write(tbl[i].addr, tbl[i].data);
                OP_RD: begin
                    cpu_read(tbl[i].addr, rdv);
                    check(tbl[i].name, 16'(rdv), tbl[i].exp);
                end
                OP_PA: check(tbl[i].name, 16'(pa_out), tbl[i].exp);
                OP_PC: check(tbl[i].name, 16'(pc_out), tbl[i].exp);
                OP_OE: check(tbl[i].name, {6'b0, pa_oe, pb_oe, pc_oe}, tbl[i].exp);
                default: ;
            endcase
        end

        // Strobed input on port A
        pa_in = 8'h3C;
        cpu_write(2'd3, 8'hB0);
        cpu_write(2'd3, 8'h09);
        stb[0] = 1'b0;
        tick();
        tick();
        check("bf_a_early", 16'(bf[0]), 16'h0000);
        tick();
        check("bf_a_stb", 16'(bf[0]), 16'h0001);
        check("intr_a_stb_low", 16'(intr[0]), 16'h0000);
        stb[0] = 1'b1;
        n = 0;
        while (intr[0] !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("intr_a_in", 16'(intr[0]), 16'h0001);
        cpu_read(2'd3, rdv);
        check("status_in", 16'(rdv), 16'h0038);
        cpu_read(2'd0, rdv);
        check("latch_a", 16'(rdv), 16'h003C);
        check("bf_a_rd_clr", 16'(bf[0]), 16'h0000);
        check("intr_a_rd_clr", 16'(intr[0]), 16'h0000);

        // Second strobe overwrites the latch while full
        pa_in  = 8'h11;
        stb[0] = 1'b0;
        repeat (4) tick();
        stb[0] = 1'b1;
        repeat (4) tick();
        check("bf_a_first", 16'(bf[0]), 16'h0001);
        pa_in  = 8'h77;
        stb[0] = 1'b0;
        repeat (4) tick();
        stb[0] = 1'b1;
        repeat (4) tick();
        check("bf_a_still", 16'(bf[0]), 16'h0001);
        cpu_read(2'd0, rdv);
        check("latch_a_over", 16'(rdv), 16'h0077);

        // Reset in the middle of a handshake, with a write pending
        stb[0] = 1'b0;
        repeat (4) tick();
        check("bf_before_rst", 16'(bf[0]), 16'h0001);
        reset = 1'b1;
        cs    = 1'b0;
        a     = 2'd0;
        d_in  = 8'hFF;
        rd    = 1'b1;
        wr    = 1'b0;
        tick();
        reset = 1'b0;
        cs    = 1'b1;
        wr    = 1'b1;
        check("rst_bf_intr", {12'b0, bf, intr}, 16'h0000);
        check("rst_pa_out", 16'(pa_out), 16'h0000);
        check("rst_pc_out", 16'(pc_out), 16'h0000);
        check("rst_oe", {6'b0, pa_oe, pb_oe, pc_oe}, 16'h0000);
        check("rst_d_out", 16'(d_out), 16'h0000);
        stb[0] = 1'b1;
        tick();
        cpu_read(2'd3, rdv);
        check("rst_status", 16'(rdv), 16'h0000);

        // Strobed output on port A
        cpu_write(2'd3, 8'hA0);
        cpu_write(2'd3, 8'h09);
        cpu_write(2'd0, 8'h55);
        check("out_pa", 16'(pa_out), 16'h0055);
        check("out_pa_oe", 16'(pa_oe), 16'h0001);
        check("out_bf_set", 16'(bf[0]), 16'h0001);
        check("out_intr_clr", 16'(intr[0]), 16'h0000);
        stb[0] = 1'b0;
        tick();
        tick();
        check("out_bf_hold", 16'(bf[0]), 16'h0001);
        tick();
        check("out_bf_ack", 16'(bf[0]), 16'h0000);
        check("out_intr_ack_low", 16'(intr[0]), 16'h0000);
        stb[0] = 1'b1;
        n = 0;
        while (intr[0] !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("out_intr_set", 16'(intr[0]), 16'h0001);
        repeat (3) tick();
        check("out_intr_hold", 16'(intr[0]), 16'h0001);
        cpu_write(2'd0, 8'hAA);
        check("out_intr_wr_clr", 16'(intr[0]), 16'h0000);
        check("out_bf_again", 16'(bf[0]), 16'h0001);

        // Bus enable: both strobes low is no access, a read drives
        cs = 1'b0;
        a  = 2'd1;
        d_in = 8'h00;
        rd = 1'b0;
        wr = 1'b0;
        #1;
        check("doe_both_low", 16'(d_oe), 16'h0000);
        tick();
        cs = 1'b1;
        rd = 1'b1;
        wr = 1'b1;
        tick();
        check("no_write_both_low", 16'(pb_out), 16'h0000);
        cs = 1'b0;
        rd = 1'b0;
        #1;
        check("doe_read", 16'(d_oe), 16'h0001);
        tick();
        rd = 1'b1;
        tick();
        cs = 1'b1;

        // Randomized mode-0 traffic against the register model
        for (int it = 0; it < 30; it++) begin
            dirs  = 4'($urandom);
            pa_in = 8'($urandom);
            pb_in = 8'($urandom);
            pc_in = 8'($urandom);
            cwv   = {1'b1, 2'b00, dirs[3], dirs[2], 1'b0, dirs[1], dirs[0]};
            cpu_write(2'd3, cwv);
            ma   = 8'h00;
            mb   = 8'h00;
            mc   = 8'h00;
            mask = {{4{dirs[2]}}, {4{dirs[0]}}};
            check("rnd_oe", {6'b0, pa_oe, pb_oe, pc_oe},
                  {6'b0, ~dirs[3], ~dirs[1], ~mask});
            for (int k = 0; k < 6; k++) begin
                op   = $urandom_range(0, 2);
                port = $urandom_range(0, 2);
                wdat = 8'($urandom);
                stb  = 2'($urandom);
                if (op == 0) begin
                    cpu_write(2'(port), wdat);
                    if (port == 0) ma = wdat;
                    else if (port == 1) mb = wdat;
                    else mc = wdat;
                end else if (op == 1) begin
                    idx = 6'($urandom);
                    b   = 1'($urandom);
                    cpu_write(2'd3, {1'b0, idx, b});
                    mc[int'(idx) % 8] = b;
                end else begin
                    if (port == 0) expv = dirs[3] ? pa_in : ma;
                    else if (port == 1) expv = dirs[1] ? pb_in : mb;
                    else expv = (pc_in & mask) | (mc & ~mask);
                    cpu_read(2'(port), rdv);
                    check("rnd_read", 16'(rdv), 16'(expv));
                end
                check("rnd_pa", 16'(pa_out), 16'(ma));
                check("rnd_pb", 16'(pb_out), 16'(mb));
                check("rnd_pc", 16'(pc_out), 16'(mc));
                check("rnd_hs_idle", {12'b0, bf, intr}, 16'h0000);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/ppi_strobed.md
PPI_STROBED -- requirements
Module: ppi_strobed

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of D and each of ports A/B/C; legal 8..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of synchroniser flops on port-side inputs.
REQ-003 SHALL have one clock and synchronous active-high reset: CLK  in  1  clock, all state on rising edge; RESET  in  1  synchronous active-high reset.
REQ-004 CS  in  1  chip select, active low.
REQ-005 RD  in  1  read strobe, active low; WR  in  1  write strobe, active low; both synchronous to CLK.
REQ-006 A  in  2  register select: 0=A, 1=B, 2=C, 3=control/status.
REQ-007 D_IN  in  DATA_W  CPU write data; D_OUT  out  DATA_W  CPU read data; D_OE  out  1  CPU bus drive enable.
REQ-008 PA_IN/PB_IN/PC_IN  in  DATA_W  pin inputs; PA_OUT/PB_OUT/PC_OUT  out  DATA_W  pin outputs.
REQ-009 PA_OE/PB_OE  out  1  port drive enable; PC_OE  out  DATA_W  per-bit drive enable.
REQ-010 STB_ACK_N  in  2  per port [0]=A,[1]=B: STB_N in mode-1 input, ACK_N in mode-1 output.
REQ-011 BF  out  2  IBF (input) or OBF, active high, per port; INTR  out  2  interrupt request per port.

Function
REQ-012 Write = cycle where ~CS & ~WR & RD and WR was high previous cycle; one action per WR strobe.
REQ-013 Write A=3, D_IN[7]=1: load control word; fields D6:5 mode A (00 mode 0, 01 mode 1, else treated as 01), D4 dir A, D3 dir C upper half, D2 mode B, D1 dir B, D0 dir C lower half; dir 1=input.
REQ-014 Control-word load SHALL clear PA/PB/PC_OUT, BF, INTR, INTE in the same edge.
REQ-015 Write A=3, D_IN[7]=0 (BSR): bit index D_IN[6:1] mod DATA_W of PC_OUT := D_IN[0]; in mode 1, index 4 also writes INTE_A, index 2 writes INTE_B.
REQ-016 Write A=0/1/2: load PA/PB/PC_OUT; ignored for port bits configured input except latch still updates.
REQ-017 D_OE = ~CS & ~RD & WR combinationally; D_OUT registered, valid from first edge after RD falls; RD & WR both low: no action, D_OE 0.
REQ-018 Read A=0/1: mode 0 input returns synchronised pins; mode 1 input returns input latch; output returns PA/PB_OUT.
REQ-019 Read A=2: per bit, synchronised PC_IN if input, else PC_OUT.
REQ-020 Read A=3 returns status: bit0 INTR_B, bit1 BF_B, bit2 INTE_B, bit3 INTR_A, bit4 BF_A, bit5 INTE_A, others 0.
REQ-021 PA_OE = dir A output; PB_OE likewise; PC_OE upper half = ~D3, lower half = ~D0 (half = DATA_W/2).
REQ-022 STB_ACK_N and Px_IN pass SYNC_STAGES flops; edges detected on synchronised value.
REQ-023 Mode-1 input: STB_N falling edge latches synchronised Px_IN, BF:=1, exactly SYNC_STAGES+1 edges after pin fall.
REQ-024 Mode-1 input INTR = BF & INTE & STB_N high (synchronised), registered.
REQ-025 Mode-1 input: end of read of that port (RD rising, CS low) clears BF and INTR; STB fall with BF=1 overwrites latch, BF stays 1; STB fall and read end same edge: latch new data, BF stays 1.
REQ-026 Mode-1 output: CPU write to port sets BF:=1, clears INTR; ACK_N falling edge clears BF; INTR:=1 when BF=0 & ACK_N high & INTE, held until next port write.
REQ-027 Mode 0: BF and INTR held 0; STB_ACK_N ignored.

Reset
REQ-028 RESET SHALL set control word 8'h9B (all inputs, mode 0), PA/PB/PC_OUT 0, all OE 0, BF 0, INTR 0, INTE 0, D_OUT 0, synchronisers 0 over all stages; RESET dominates any same-cycle access or strobe.

Structure
REQ-029 Package ppi_pkg SHALL hold mode encodings, control-word field positions, status bit positions, reset control word 8'h9B.
REQ-030 Sub-module ppi_hs_port SHALL implement one strobed port (sync, latch, BF, INTR, INTE), instantiated twice (A, B).

Verification
REQ-031 Reset, read A=3 -> 8'h00; PA_OE=PB_OE=0, PC_OE=0.
REQ-032 Write 8'h80 then A=0 with 8'hA5 -> PA_OE=1, PA_OUT=8'hA5; write 8'h80 again -> PA_OUT=0.
REQ-033 Mode 0 output C, BSR writes 8'h0F then 8'h0E -> PC_OUT bit7 goes 1 then 0, others unchanged.
REQ-034 CW 8'hB0, BSR 8'h09 (INTE_A=1), PA_IN=8'h3C, pulse STB_N -> BF[0]=1 after 3 edges, INTR[0]=1 after STB_N rises; read A=0 returns 8'h3C, BF[0]=INTR[0]=0 after RD rises.
REQ-035 CW 8'hA0, INTE_A=1, write A=0 8'h55 -> BF[0]=1, INTR[0]=0; ACK_N pulse -> BF[0]=0, then INTR[0]=1.
REQ-036 Mode-1 input with BF[0]=1, second STB with PA_IN=8'h77 -> read returns 8'h77; RESET mid-handshake -> all state per REQ-028 next edge.
